// File: rtl/count_seq_monitor.sv
// ============================================================================
// count_seq_monitor: classifies a sampled counter stream as up, down or faulty.
// Optional wrap counter: COUNT_SEQ_MON_WRAP_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module count_seq_monitor #(
  parameter int WIDTH      = 3,
  parameter int LOCK_STEPS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] Q,
  output logic             locked,
  output logic             dir,
  output logic             err,
  output logic [3:0]       wraps,
  output logic [WIDTH-1:0] last_q
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_all_ones = '1;
  localparam logic [2:0]       c_lock     = 3'(LOCK_STEPS);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_run_cnt, w_run_cnt_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] r_last_q, w_last_q_nxt;

  logic [WIDTH-1:0] w_delta;
  logic             w_up;
  logic             w_down;
  logic             w_step;

  assign w_delta = Q - r_last_q;
  assign w_up    = (w_delta == c_one);
  assign w_down  = (w_delta == c_all_ones);
  assign w_step  = w_up | w_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_run_cnt <= 3'd0;
      r_locked  <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_last_q  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_cnt_nxt;
      r_locked  <= w_locked_nxt;
      r_dir     <= w_dir_nxt;
      r_err     <= w_err_nxt;
      r_last_q  <= w_last_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_run_cnt_nxt = r_run_cnt;
    w_locked_nxt  = r_locked;
    w_dir_nxt     = r_dir;
    w_err_nxt     = r_err;
    w_last_q_nxt  = r_last_q;
    if (!enable) begin
      w_state_nxt   = ST_IDLE;
      w_locked_nxt  = 1'b0;
      w_run_cnt_nxt = 3'd0;
    end else begin
      w_last_q_nxt = Q;
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_ACQ;
          w_run_cnt_nxt = 3'd0;
        end
        ST_ACQ: begin
          if (w_step) begin
            // An empty run adopts any direction; a reversal restarts the run at 1.
            w_dir_nxt     = w_up;
            w_run_cnt_nxt = (w_up == r_dir || r_run_cnt == 3'd0) ?
                            3'(r_run_cnt + 3'd1) : 3'd1;
            if (w_run_cnt_nxt >= c_lock) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_run_cnt_nxt = 3'd0;
          end
        end
        ST_LOCKED: begin
          if (w_step && (w_up != r_dir)) begin
            w_state_nxt   = ST_ACQ;
            w_locked_nxt  = 1'b0;
            w_dir_nxt     = w_up;
            w_run_cnt_nxt = 3'd1;
          end else if (!w_step) begin
            w_state_nxt  = ST_FAULT;
            w_locked_nxt = 1'b0;
            w_err_nxt    = 1'b1;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

`ifdef COUNT_SEQ_MON_WRAP_CNT_EN
  logic [3:0] r_wraps;
  logic       w_wrap;

  // A wrap is an in-direction step landing on the opposite extreme.
  assign w_wrap = enable && (r_state == ST_LOCKED) && w_step && (w_up == r_dir) &&
                  (Q == (w_up ? '0 : c_all_ones));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wraps <= 4'd0;
    end else if (w_wrap && (r_wraps != 4'd15)) begin
      r_wraps <= r_wraps + 4'd1;
    end
  end

  assign wraps = r_wraps;
`else
  assign wraps = 4'd0;
`endif

  assign locked = r_locked;
  assign dir    = r_dir;
  assign err    = r_err;
  assign last_q = r_last_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_monitor.sv
// ============================================================================
// tb_count_seq_monitor: directed-vector bench for count_seq_monitor.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_count_seq_monitor;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [2:0] Q;
  logic       locked;
  logic       dir;
  logic       err;
  logic [3:0] wraps;
  logic [2:0] last_q;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef COUNT_SEQ_MON_WRAP_CNT_EN
  localparam int WRAP_EN = 1;
`else
  localparam int WRAP_EN = 0;
`endif

  count_seq_monitor #(.WIDTH(3), .LOCK_STEPS(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .Q      (Q),
    .locked (locked),
    .dir    (dir),
    .err    (err),
    .wraps  (wraps),
    .last_q (last_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [2:0] q, input logic en);
    @(negedge clk);
    Q      = q;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_wraps(input int n);
    return (WRAP_EN != 0) ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    Q      = 3'd5;
    #12;
    check_value("rst_locked", locked, 0);
    check_value("rst_dir",    dir,    0);
    check_value("rst_err",    err,    0);
    check_value("rst_wraps",  wraps,  0);
    check_value("rst_last_q", last_q, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up run 0..7,0
    tick(3'd0, 1'b1);
    check_value("up_first_last_q", last_q, 0);
    tick(3'd1, 1'b1);
    check_value("up_s1_locked", locked, 0);
    tick(3'd2, 1'b1);
    check_value("up_s2_locked", locked, 1);
    check_value("up_s2_dir",    dir,    1);
    for (int i = 3; i <= 7; i++) tick(3'(i), 1'b1);
    check_value("up_s7_wraps",  wraps,  0);
    check_value("up_s7_last_q", last_q, 7);
    tick(3'd0, 1'b1);
    check_value("up_wrap_wraps",  wraps,  exp_wraps(1));
    check_value("up_wrap_locked", locked, 1);
    check_value("up_wrap_err",    err,    0);

    // One disabled edge: back to idle, Q ignored, wraps and dir kept
    tick(3'd4, 1'b0);
    check_value("dis_locked", locked, 0);
    check_value("dis_dir",    dir,    1);
    check_value("dis_last_q", last_q, 0);
    check_value("dis_wraps",  wraps,  exp_wraps(1));

    // Down run 7..0,7
    tick(3'd7, 1'b1);
    tick(3'd6, 1'b1);
    check_value("dn_s6_locked", locked, 0);
    tick(3'd5, 1'b1);
    check_value("dn_s5_locked", locked, 1);
    check_value("dn_s5_dir",    dir,    0);
    for (int i = 4; i >= 0; i--) tick(3'(i), 1'b1);
    check_value("dn_s0_wraps", wraps, exp_wraps(1));
    tick(3'd7, 1'b1);
    check_value("dn_wrap_wraps",  wraps,  exp_wraps(2));
    check_value("dn_wrap_locked", locked, 1);

    // Jump fault
    tick(3'd0, 1'b0);
    tick(3'd1, 1'b1);
    tick(3'd2, 1'b1);
    tick(3'd3, 1'b1);
    check_value("jmp_lock_locked", locked, 1);
    tick(3'd6, 1'b1);
    check_value("jmp_err",    err,    1);
    check_value("jmp_locked", locked, 0);
    check_value("jmp_last_q", last_q, 6);
    tick(3'd7, 1'b1);
    check_value("flt_locked", locked, 0);
    check_value("flt_last_q", last_q, 7);
    tick(3'd3, 1'b0);
    check_value("flt_idle_err", err, 1);
    tick(3'd0, 1'b1);
    tick(3'd1, 1'b1);
    tick(3'd2, 1'b1);
    check_value("relock_locked", locked, 1);
    check_value("relock_err",    err,    1);

    // Reversal 2,3,4,3,2,1
    tick(3'd0, 1'b0);
    tick(3'd2, 1'b1);
    tick(3'd3, 1'b1);
    tick(3'd4, 1'b1);
    check_value("rev_up_locked", locked, 1);
    check_value("rev_up_dir",    dir,    1);
    tick(3'd3, 1'b1);
    check_value("rev_flip_locked", locked, 0);
    check_value("rev_flip_dir",    dir,    0);
    tick(3'd2, 1'b1);
    check_value("rev_dn_locked", locked, 1);
    check_value("rev_dn_dir",    dir,    0);
    tick(3'd1, 1'b1);
    check_value("rev_hold_locked", locked, 1);
    check_value("pre_rst_wraps", wraps, exp_wraps(2));

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_value("arst_locked", locked, 0);
    check_value("arst_dir",    dir,    0);
    check_value("arst_err",    err,    0);
    check_value("arst_wraps",  wraps,  0);
    check_value("arst_last_q", last_q, 0);
    #1 rst_n = 1'b1;
    tick(3'd3, 1'b1);
    check_value("post_s1_last_q", last_q, 3);
    tick(3'd4, 1'b1);
    check_value("post_s2_locked", locked, 0);
    tick(3'd5, 1'b1);
    check_value("post_s3_locked", locked, 1);
    check_value("post_s3_dir",    dir,    1);

    // Hold while locked
    tick(3'd5, 1'b1);
    check_value("hold_err",    err,    1);
    check_value("hold_locked", locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
